uart_txq_feeder: RTL and testbench

UART_TXQ_FEEDER -- requirements
Module: uart_txq_feeder

---
 rtl/uart_txq_feeder.sv | 159 +++++++++++++++
 tb/tb_uart_txq_feeder.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txq_feeder.sv
// uart_txq_feeder: circular byte FIFO that hands bytes one at a time to a UART transmitter.
// Define UART_TXQ_OVF_EN to add the sticky overflow flag and its ovf_clr/overflow ports.
module uart_txq_feeder #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  send_en,
   output logic [7:0]            data_byte,
   input  logic                  uart_state,
   input  logic                  tx_done
`ifdef UART_TXQ_OVF_EN
   ,
   input  logic                  ovf_clr,
   output logic                  overflow
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE
   } feederState_e;

   feederState_e          r_state;
   feederState_e          w_nextState;

   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wrPtr;
   logic [DEPTH_LOG2-1:0] r_rdPtr;
   logic [DEPTH_LOG2:0]   r_level;
   logic [DEPTH_LOG2:0]   w_levelNext;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_sendEn;
   logic [7:0]            r_dataByte;
   logic                  w_push;
   logic                  w_pop;

   // full is registered, so a write arriving while full is refused even if a pop frees a slot on that edge
   assign w_push = wr_en && !r_full;

   always_comb begin
      w_levelNext = r_level;
      case ({w_push, w_pop})
         2'b10:   w_levelNext = r_level + 1'b1;
         2'b01:   w_levelNext = r_level - 1'b1;
         default: w_levelNext = r_level;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         r_level <= w_levelNext;
         r_full  <= (w_levelNext == LEVEL_FULL);
         r_empty <= (w_levelNext == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (!r_empty && !uart_state) begin
               w_nextState = LAUNCH;
            end
         end
         LAUNCH: begin
            w_nextState = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Pop uses the pre-edge empty flag, so a byte written into an empty FIFO waits one edge
   always_comb begin
      w_pop = 1'b0;
      if ((r_state == IDLE) && !r_empty && !uart_state) begin
         w_pop = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sendEn   <= 1'b0;
         r_dataByte <= 8'h00;
      end else begin
         r_sendEn <= w_pop;
         if (w_pop) begin
            r_dataByte <= r_mem[r_rdPtr];
         end
      end
   end

`ifdef UART_TXQ_OVF_EN
   logic r_overflow;

   // A drop on the same edge as ovf_clr keeps the flag set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (wr_en && r_full) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

   assign overflow = r_overflow;
`endif

   assign full      = r_full;
   assign empty     = r_empty;
   assign level     = r_level;
   assign send_en   = r_sendEn;
   assign data_byte = r_dataByte;

endmodule

// File: tb/tb_uart_txq_feeder.sv
// tb_uart_txq_feeder: randomized and directed stimulus against a queue-based reference model.
// Build with UART_TXQ_OVF_EN defined to also exercise the overflow flag.
`timescale 1ns/1ps
module tb_uart_txq_feeder;

   localparam int DEPTH_LOG2   = 4;
   localparam int DEPTH        = 16;
   localparam int FRAME_CYCLES = 10;
   localparam int DRAIN_LIMIT  = 1000;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                wrEn;
   logic [7:0]          wrData;
   logic                forceBusy;
   logic                uartState;
   logic                txBusy;
   logic                txDone;
   int                  txCnt;
   logic                dutFull;
   logic                dutEmpty;
   logic [DEPTH_LOG2:0] dutLevel;
   logic                dutSendEn;
   logic [7:0]          dutDataByte;
`ifdef UART_TXQ_OVF_EN
   logic                ovfClr;
   logic                dutOverflow;
   logic                expOvf;
`endif

   logic [7:0]          modelQ[$];
   logic                awaitingDone;
   logic                justLaunched;
   logic                expSend;
   logic [7:0]          expData;
   int                  modelPreSize;
   logic                modelPop;

   logic [7:0]          launchLog[$];
   int                  gapLog[$];
   int                  lastDoneCycle;
   int                  cycleNum;
   logic                prevSendEn;
   logic                checkEn;

   int                  testsRun;
   int                  testsFailed;

   assign uartState = forceBusy | txBusy;

   uart_txq_feeder #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wrEn),
      .wr_data    (wrData),
      .full       (dutFull),
      .empty      (dutEmpty),
      .level      (dutLevel),
      .send_en    (dutSendEn),
      .data_byte  (dutDataByte),
      .uart_state (uartState),
      .tx_done    (txDone)
`ifdef UART_TXQ_OVF_EN
      ,
      .ovf_clr    (ovfClr),
      .overflow   (dutOverflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [7:0] data, input logic busy);
      @(negedge clk);
      wrEn      = we;
      wrData    = data;
      forceBusy = busy;
`ifdef UART_TXQ_OVF_EN
      ovfClr    = 1'b0;
`endif
   endtask

`ifdef UART_TXQ_OVF_EN
   task automatic applyClear(input logic we, input logic [7:0] data);
      @(negedge clk);
      wrEn   = we;
      wrData = data;
      ovfClr = 1'b1;
   endtask
`endif

   task automatic waitDrained(input string tag);
      int waited;
      waited = 0;
      do begin
         applyStimulus(1'b0, 8'h00, 1'b0);
         waited++;
      end while ((modelQ.size() != 0 || awaitingDone || txBusy) && waited < DRAIN_LIMIT);
      checkOutput({tag, "DrainBudget"}, 32'(waited < DRAIN_LIMIT), 32'd1);
      checkOutput({tag, "Empty"}, 32'(dutEmpty), 32'd1);
   endtask

   // Reference model: a byte queue plus "one frame in flight until tx_done" bookkeeping
   initial begin
      modelQ.delete();
      awaitingDone = 1'b0;
      justLaunched = 1'b0;
      expSend      = 1'b0;
      expData      = 8'h00;
`ifdef UART_TXQ_OVF_EN
      expOvf       = 1'b0;
`endif
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            modelQ.delete();
            awaitingDone = 1'b0;
            justLaunched = 1'b0;
            expSend      = 1'b0;
            expData      = 8'h00;
`ifdef UART_TXQ_OVF_EN
            expOvf       = 1'b0;
`endif
         end else begin
            modelPreSize = modelQ.size();
            modelPop     = !awaitingDone && (modelPreSize > 0) && !uartState;
`ifdef UART_TXQ_OVF_EN
            if (wrEn && modelPreSize == DEPTH) begin
               expOvf = 1'b1;
            end else if (ovfClr) begin
               expOvf = 1'b0;
            end
`endif
            if (awaitingDone && !justLaunched && txDone) begin
               awaitingDone = 1'b0;
            end
            expSend      = modelPop;
            justLaunched = modelPop;
            if (modelPop) begin
               expData      = modelQ.pop_front();
               awaitingDone = 1'b1;
            end
            if (wrEn && modelPreSize < DEPTH) begin
               modelQ.push_back(wrData);
            end
         end
      end
   end

   // Transmitter model: busy for a frame after each launch, then a one-cycle tx_done
   initial begin
      txBusy = 1'b0;
      txDone = 1'b0;
      txCnt  = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            txBusy = 1'b0;
            txDone = 1'b0;
            txCnt  = 0;
         end else if (txDone) begin
            txDone = 1'b0;
            txBusy = 1'b0;
         end else if (dutSendEn) begin
            txBusy = 1'b1;
            txCnt  = FRAME_CYCLES;
         end else if (txCnt > 0) begin
            txCnt--;
            if (txCnt == 0) begin
               txDone = 1'b1;
            end
         end
      end
   end

   initial begin
      cycleNum      = 0;
      lastDoneCycle = -1000;
      prevSendEn    = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cycleNum++;
         if (checkEn) begin
            checkOutput("level", 32'(dutLevel), 32'(modelQ.size()));
            checkOutput("full", 32'(dutFull), 32'(modelQ.size() == DEPTH));
            checkOutput("empty", 32'(dutEmpty), 32'(modelQ.size() == 0));
            checkOutput("sendEn", 32'(dutSendEn), 32'(expSend));
            checkOutput("dataByte", 32'(dutDataByte), 32'(expData));
            checkOutput("sendEnBackToBack", 32'(dutSendEn & prevSendEn), 32'd0);
`ifdef UART_TXQ_OVF_EN
            checkOutput("overflow", 32'(dutOverflow), 32'(expOvf));
`endif
         end
         if (dutSendEn) begin
            launchLog.push_back(dutDataByte);
            gapLog.push_back(cycleNum - lastDoneCycle);
         end
         if (txDone) begin
            lastDoneCycle = cycleNum;
         end
         prevSendEn = dutSendEn;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time exceeded, got %0d cycles, expected completion", cycleNum);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] fillData[$];
      logic [7:0] wrapData[$];
      logic [7:0] d;
      int         startIdx;
      int         n;

      testsRun    = 0;
      testsFailed = 0;
      checkEn     = 1'b0;
      rst_n       = 1'b0;
      wrEn        = 1'b0;
      wrData      = 8'h00;
      forceBusy   = 1'b0;
`ifdef UART_TXQ_OVF_EN
      ovfClr      = 1'b0;
`endif
      repeat (3) @(negedge clk);
      checkEn = 1'b1;
      checkOutput("rstLevel", 32'(dutLevel), 32'd0);
      checkOutput("rstEmpty", 32'(dutEmpty), 32'd1);
      checkOutput("rstFull", 32'(dutFull), 32'd0);
      checkOutput("rstSendEn", 32'(dutSendEn), 32'd0);
      checkOutput("rstDataByte", 32'(dutDataByte), 32'h00);
      rst_n = 1'b1;

      // Single byte: launch visible on the second edge after the write is sampled
      applyStimulus(1'b1, 8'hA5, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("singleNoEarlyLaunch", 32'(dutSendEn), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("singleSendEn", 32'(dutSendEn), 32'd1);
      checkOutput("singleData", 32'(dutDataByte), 32'hA5);
      checkOutput("singleLevel", 32'(dutLevel), 32'd0);
      waitDrained("single");

      // Burst: each launch follows the previous tx_done by one cycle
      startIdx = launchLog.size();
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0);
      end
      waitDrained("burst");
      n = launchLog.size() - startIdx;
      checkOutput("burstCount", 32'(n), 32'd5);
      for (int k = 0; k < n && k < 5; k++) begin
         checkOutput($sformatf("burstOrder%0d", k), 32'(launchLog[startIdx + k]), 32'(k + 1));
         if (k > 0) begin
            checkOutput($sformatf("burstGap%0d", k), 32'(gapLog[startIdx + k]), 32'd1);
         end
      end

      // Fill with the transmitter held busy, then overflow handling and a write+pop at full
      startIdx = launchLog.size();
      fillData.delete();
      for (int i = 0; i < DEPTH; i++) begin
         d = 8'($urandom);
         fillData.push_back(d);
         applyStimulus(1'b1, d, 1'b1);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("fillLevel", 32'(dutLevel), 32'd16);
      checkOutput("fillFull", 32'(dutFull), 32'd1);
      applyStimulus(1'b1, 8'hFF, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("dropLevel", 32'(dutLevel), 32'd16);
`ifdef UART_TXQ_OVF_EN
      checkOutput("ovfSet", 32'(dutOverflow), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("ovfSticky", 32'(dutOverflow), 32'd1);
      applyClear(1'b1, 8'hFF);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("ovfSetWins", 32'(dutOverflow), 32'd1);
      applyClear(1'b0, 8'h00);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("ovfCleared", 32'(dutOverflow), 32'd0);
`endif
      applyStimulus(1'b1, 8'hEE, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("fullPopLevel", 32'(dutLevel), 32'd15);
      checkOutput("fullPopFull", 32'(dutFull), 32'd0);
`ifdef UART_TXQ_OVF_EN
      applyClear(1'b0, 8'h00);
`endif
      waitDrained("fill");
      n = launchLog.size() - startIdx;
      checkOutput("fillCount", 32'(n), 32'd16);
      for (int k = 0; k < n && k < DEPTH; k++) begin
         checkOutput($sformatf("fillOrder%0d", k), 32'(launchLog[startIdx + k]), 32'(fillData[k]));
      end

      // Simultaneous accepted write and pop at level 3
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 8'($urandom), 1'b1);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("lvl3Before", 32'(dutLevel), 32'd3);
      applyStimulus(1'b1, 8'h77, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("lvl3After", 32'(dutLevel), 32'd3);
      waitDrained("lvl3");

      // Wrap: 20 spaced writes while the transmitter drains, order must survive the pointer wrap
      startIdx = launchLog.size();
      wrapData.delete();
      for (int i = 0; i < 20; i++) begin
         d = 8'($urandom);
         wrapData.push_back(d);
         applyStimulus(1'b1, d, 1'b0);
         repeat ($urandom_range(3, 7)) applyStimulus(1'b0, 8'h00, 1'b0);
      end
      waitDrained("wrap");
      n = launchLog.size() - startIdx;
      checkOutput("wrapCount", 32'(n), 32'd20);
      for (int k = 0; k < n && k < 20; k++) begin
         checkOutput($sformatf("wrapOrder%0d", k), 32'(launchLog[startIdx + k]), 32'(wrapData[k]));
      end

      // Reset while waiting for tx_done with four bytes still queued
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'(8'h40 + i), 1'b1);
      end
      repeat (4) applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("midFrameLevel", 32'(dutLevel), 32'd4);
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("midRstLevel", 32'(dutLevel), 32'd0);
      checkOutput("midRstEmpty", 32'(dutEmpty), 32'd1);
      checkOutput("midRstSendEn", 32'(dutSendEn), 32'd0);
      checkOutput("midRstDataByte", 32'(dutDataByte), 32'h00);
      rst_n = 1'b1;
      startIdx = launchLog.size();
      repeat (30) applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("noLaunchAfterRst", 32'(launchLog.size() - startIdx), 32'd0);
      applyStimulus(1'b1, 8'h3C, 1'b0);
      waitDrained("postRst");
      n = launchLog.size() - startIdx;
      checkOutput("postRstCount", 32'(n), 32'd1);
      if (n > 0) begin
         checkOutput("postRstData", 32'(launchLog[startIdx]), 32'h3C);
      end

      // Random traffic with random busy periods, overflows and clears
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            forceBusy = ~forceBusy;
         end
         applyStimulus(1'($urandom_range(0, 2) == 0), 8'($urandom), forceBusy);
`ifdef UART_TXQ_OVF_EN
         ovfClr = 1'($urandom_range(0, 9) == 0);
`endif
      end
      waitDrained("random");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
